// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and the FIFO it feeds:
// FSM state encoding and a ceiling-log2 helper for sizing counters/pointers.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// set request at or above the pointer position, wrapping around.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [NUM_REQ-1:0] w_req_rot;
  logic [NUM_REQ-1:0] w_gnt_rot;

  // Rotate requests right so the pointer position lands on bit 0.
  assign w_req_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector wins (descending overwrite).
  always_comb begin
    w_gnt_rot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_gnt_rot = NUM_REQ'(1) << i;
    end
  end

  // Rotate the winner back left by the pointer to original positions.
  assign o_gnt = NUM_REQ'({w_gnt_rot, w_gnt_rot} >> (NUM_REQ - int'(i_ptr)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time ownership of a
// downstream synchronous FIFO write port for a burst of up to BURST_LEN
// words, ending early on req_last or when the owner drops req_valid.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W  = clog2(NUM_REQ);
  localparam int BEAT_W = clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [BEAT_W-1:0]   r_beat;

  logic [NUM_REQ-1:0]    w_pick;
  logic                  w_gvalid;
  logic                  w_glast;
  logic                  w_beat;
  logic                  w_burst_done;
  logic [PTR_W-1:0]      w_gidx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // r_grant is zero outside GRANT, so these reduce to zero when idle.
  assign w_gvalid     = |(req_valid & r_grant);
  assign w_glast      = |(req_last & r_grant);
  assign w_beat       = (r_state == ST_GRANT) && w_gvalid && !fifo_full;
  assign w_burst_done = w_glast || (r_beat == LAST_BEAT);

  // Index of the current owner, used to advance the round-robin pointer.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  assign w_next_ptr = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  // Select the granted requester's word for the FIFO write port.
  always_comb begin
    w_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration FSM: IDLE picks an owner, GRANT streams its burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_pick;
            r_beat  <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_beat) r_beat <= r_beat + BEAT_W'(1);
          // Owner abandons, or the burst ends on last/BURST_LEN-th beat.
          if (!w_gvalid || (w_beat && w_burst_done)) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset suppresses writes combinationally so no beat lands in that cycle.
  assign fifo_wr_en   = w_beat && !rst;
  assign req_ready    = (w_beat && !rst) ? r_grant : '0;
  assign fifo_wr_data = w_wr_data;
  assign grant        = r_grant;
  assign busy         = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of the round-robin FIFO write arbiter.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [3:0]  grant;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .BURST_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic set_word(input int i, input logic [15:0] v);
    req_data[i*16 +: 16] = v;
  endtask

  function automatic logic [15:0] rr_word(input int i, input int c);
    return 16'(32'hA000 + i * 256 + c);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; fifo_full = 1'b0; req_data = '1;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dut.r_rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
    rst = 1'b0; req_valid = '0; req_last = '0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_last = '0; set_word(0, 16'h1000);
    #1;
    checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0) begin errors++; $display("FAIL single_bubble: wr_en=%b grant=%b want 0/0000", fifo_wr_en, grant); end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      set_word(0, 16'(16'h1000 + w));
      req_last = (w == 2) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant%0d: got %b want 0001", w, grant); end
      checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en%0d: got %b want 1", w, fifo_wr_en); end
      checks++; if (fifo_wr_data !== 16'(16'h1000 + w)) begin errors++; $display("FAIL single_data%0d: got %h want %h", w, fifo_wr_data, 16'(16'h1000 + w)); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready%0d: got %b want 0001", w, req_ready); end
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    checks++; if (busy !== 1'b0 || grant !== 4'b0) begin errors++; $display("FAIL single_done: busy=%b grant=%b want 0/0000", busy, grant); end
    checks++; if (dut.r_rr_ptr !== 2'd1) begin errors++; $display("FAIL single_rr_ptr: got %0d want 1", dut.r_rr_ptr); end
  endtask

  task automatic test_round_robin();
    int cnt [4];
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int o = 0; o < 5; o++) begin
      k = o % 4;
      @(negedge clk);
      req_valid = 4'hF; req_last = '0;
      for (int i = 0; i < 4; i++) set_word(i, rr_word(i, cnt[i]));
      #1;
      checks++; if (grant !== 4'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: grant=%b wr_en=%b want 0000/0", o, grant, fifo_wr_en); end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_word(i, rr_word(i, cnt[i]));
        #1;
        checks++; if (grant !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant%0d_%0d: got %b want %b", o, b, grant, 4'(1 << k)); end
        checks++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== rr_word(k, cnt[k])) begin errors++; $display("FAIL rr_write%0d_%0d: wr_en=%b data=%h want 1/%h", o, b, fifo_wr_en, fifo_wr_data, rr_word(k, cnt[k])); end
        cnt[k]++;
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    int nwr;
    int cntw;
    logic full_c;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_last = '0; set_word(1, 16'hB000);
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_bubble: got %b want 0", fifo_wr_en); end
    nwr = 0; cntw = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      full_c = (c >= 2 && c < 7);
      fifo_full = full_c;
      set_word(1, 16'(16'hB000 + nwr));
      #1;
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL full_grant%0d: got %b want 0010", c, grant); end
      checks++; if (fifo_wr_en !== !full_c) begin errors++; $display("FAIL full_wr_en%0d: got %b want %b", c, fifo_wr_en, !full_c); end
      checks++; if (req_ready !== (full_c ? 4'b0000 : 4'b0010)) begin errors++; $display("FAIL full_ready%0d: got %b want %b", c, req_ready, (full_c ? 4'b0000 : 4'b0010)); end
      if (fifo_wr_en === 1'b1) cntw++;
      if (!full_c) begin
        checks++; if (fifo_wr_data !== 16'(16'hB000 + nwr)) begin errors++; $display("FAIL full_data%0d: got %h want %h", c, fifo_wr_data, 16'(16'hB000 + nwr)); end
        nwr++;
      end
    end
    @(negedge clk);
    fifo_full = 1'b0; req_valid = '0;
    #1;
    checks++; if (cntw !== 4) begin errors++; $display("FAIL full_total: got %0d want 4", cntw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_exit_busy: got %b want 0", busy); end
    checks++; if (dut.r_rr_ptr !== 2'd2) begin errors++; $display("FAIL full_rr_ptr: got %0d want 2", dut.r_rr_ptr); end
  endtask

  task automatic test_abandon();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_last = '0; set_word(2, 16'hC000);
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL ab_bubble: got %b want 0", fifo_wr_en); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL ab_beat: grant=%b wr_en=%b want 0100/1", grant, fifo_wr_en); end
    @(negedge clk);
    req_valid = 4'b1000; set_word(3, 16'hD000);
    #1;
    checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL ab_drop: wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL ab_idle: grant=%b busy=%b want 0000/0", grant, busy); end
    checks++; if (dut.r_rr_ptr !== 2'd3) begin errors++; $display("FAIL ab_rr_ptr: got %0d want 3", dut.r_rr_ptr); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL ab_next_grant: got %b want 1000", grant); end
    checks++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'hD000) begin errors++; $display("FAIL ab_next_write: wr_en=%b data=%h want 1/d000", fifo_wr_en, fifo_wr_data); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_last = 4'b0001; set_word(0, 16'hE000);
    @(negedge clk); #1;
    checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rm_pre_write: got %b want 1", fifo_wr_en); end
    @(negedge clk);
    req_valid = 4'b0100; req_last = '0; set_word(2, 16'hE100);
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rm_beat1: grant=%b wr_en=%b want 0100/1", grant, fifo_wr_en); end
    @(negedge clk);
    set_word(2, 16'hE101); rst = 1'b1;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rm_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    #1;
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_after: grant=%b busy=%b want 0000/0", grant, busy); end
    checks++; if (dut.r_rr_ptr !== 2'd0) begin errors++; $display("FAIL rm_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
  endtask

  task automatic test_random();
    int seq [4];
    int exp [4];
    int nw;
    int idx;
    int total;
    do_reset();
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp[i] = 0; end
    nw = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 3) == 0);
        set_word(i, 16'((i << 12) | (seq[i] & 32'hFFF)));
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) begin errors++; $display("FAIL rnd_full_write cyc%0d: wr_en=1 while full", cyc); end
      checks++; if ((req_ready & ~req_valid) !== 4'b0 || (fifo_wr_en !== 1'b1 && req_ready !== 4'b0)) begin errors++; $display("FAIL rnd_ready cyc%0d: ready=%b valid=%b wr_en=%b", cyc, req_ready, req_valid, fifo_wr_en); end
      if (fifo_wr_en === 1'b1) begin
        idx = int'(fifo_wr_data[15:12]);
        checks++;
        if (idx >= 4) begin
          errors++; $display("FAIL rnd_order cyc%0d: data=%h has bad requester id", cyc, fifo_wr_data);
        end else if (req_ready !== 4'(1 << idx) || int'(fifo_wr_data[11:0]) != (exp[idx] & 32'hFFF)) begin
          errors++; $display("FAIL rnd_order cyc%0d: data=%h ready=%b want seq %0d ready %b", cyc, fifo_wr_data, req_ready, exp[idx] & 32'hFFF, 4'(1 << idx));
        end
        if (idx < 4) exp[idx]++;
        nw++;
      end
      for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) seq[i]++;
    end
    @(negedge clk);
    req_valid = '0; fifo_full = 1'b0;
    total = seq[0] + seq[1] + seq[2] + seq[3];
    checks++; if (total != nw || nw == 0) begin errors++; $display("FAIL rnd_total: accepted=%0d written=%0d want equal and nonzero", total, nw); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
